// File: rtl/led_pattern_player_pkg.sv
// Shared constants for the LED pattern player: FSM encodings, direction values
// and default geometry of the pattern ROM and step timer.
package led_pattern_player_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int NUM_PATTERNS_DEF = 18;
  localparam int ADDR_W_DEF       = 5;
  localparam int DATA_W_DEF       = 10;
  localparam int BASE_DIV_DEF     = 12_500_000;
  localparam int SPEED_W          = 2;

  // Counter width able to hold the slowest period, BASE_DIV << 3.
  function automatic int period_width(input int base_div);
    return $clog2((base_div << ((1 << SPEED_W) - 1)) + 1);
  endfunction

endpackage

// File: rtl/led_pattern_player_if.sv
// Board-side controls, ROM bus and LED outputs of the pattern player.
// slave = the player itself, master = whatever drives controls and the ROM.
interface led_pattern_player_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 10
);

  logic              run;
  logic              step;
  logic              restart;
  logic              dir;
  logic [1:0]        speed;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] led;
  logic              step_tick;
  logic              wrap;

  modport master (
    output run, step, restart, dir, speed, rom_data,
    input  rom_addr, led, step_tick, wrap
  );

  modport slave (
    input  run, step, restart, dir, speed, rom_data,
    output rom_addr, led, step_tick, wrap
  );

endinterface

// File: rtl/led_pattern_player_step_prescaler.sv
// Step timer: counts 0..period-1 while enabled and flags the terminal count.
// The compare is against the live period so a speed change acts at once.
module step_prescaler #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  // ">=" rather than "==" so a shortened period never lets the count run past it.
  assign terminal = (count >= (period - CNT_W'(1)));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_player.sv
// Plays a combinational pattern ROM onto the LEDs: run/hold/step/restart FSM,
// wrapping address counter driven by the step timer, and a registered LED stage.
module led_pattern_player
  import led_pattern_player_pkg::*;
#(
  parameter int NUM_PATTERNS = NUM_PATTERNS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BASE_DIV     = BASE_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pattern_player_if.slave  bus
);

  localparam int              CNT_W     = period_width(BASE_DIV);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PATTERNS - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  period;
  logic              pre_en;
  logic              pre_clr;
  logic              terminal;
  logic              advance;
  logic              at_end;
  logic [ADDR_W-1:0] next_addr;

  assign period = CNT_W'(BASE_DIV) << bus.speed;

  step_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pre_clr),
    .en       (pre_en),
    .period   (period),
    .terminal (terminal)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pre_en    = 1'b0;
    advance   = 1'b0;
    at_end    = 1'b0;
    next_addr = bus.rom_addr;

    if (!bus.restart) begin
      pre_en  = (state == ST_PLAY) && bus.run;
      advance = ((state == ST_PLAY) && bus.run && terminal) ||
                ((state == ST_HOLD) && !bus.run && bus.step);
    end

    if (bus.dir == DIR_FWD) begin
      at_end    = (bus.rom_addr == LAST_ADDR);
      next_addr = at_end ? '0 : bus.rom_addr + ADDR_W'(1);
    end else begin
      at_end    = (bus.rom_addr == '0);
      next_addr = at_end ? LAST_ADDR : bus.rom_addr - ADDR_W'(1);
    end
  end

  // Prescaler is held at zero whenever it is not actively timing a PLAY step.
  assign pre_clr = !pre_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (bus.restart) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.run)  state <= ST_PLAY;
        ST_PLAY: if (!bus.run) state <= ST_HOLD;
        ST_HOLD: if (bus.run)  state <= ST_PLAY;
        default:               state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rom_addr  <= '0;
      bus.led       <= '0;
      bus.step_tick <= 1'b0;
      bus.wrap      <= 1'b0;
    end else begin
      bus.led       <= (state == ST_IDLE) ? '0 : bus.rom_data;
      bus.step_tick <= advance;
      bus.wrap      <= advance && at_end;
      if (bus.restart || (state == ST_IDLE)) begin
        bus.rom_addr <= '0;
      end else if (advance) begin
        bus.rom_addr <= next_addr;
      end
    end
  end

  a_addr_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    int'(bus.rom_addr) < NUM_PATTERNS);

  a_wrap_with_tick : assert property (@(posedge clk) disable iff (!rst_n)
    bus.wrap |-> bus.step_tick);

endmodule
